// File: rtl/ex_mem_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_skid_stage
// Description : EX->MEM pipeline stage with valid/ready handshake, 2-entry
//               skid buffer, branch-shadow tracking and zeroed bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_skid_stage #(
    parameter int XLEN        = 64,
    parameter int PAYLOAD_W   = 208,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_inst,
    input  logic                 in_branch,
    input  logic [XLEN-1:0]      in_branch_tgt,
    input  logic                 in_slot_end,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [XLEN-1:0]      out_pc,
    output logic [31:0]          out_inst,
    output logic                 branch_tag,
    output logic [XLEN-1:0]      branch_pc,
    output logic [1:0]           occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [PAYLOAD_W-1:0]   r_head_payload, r_skid_payload;
    logic [XLEN-1:0]        r_head_pc, r_skid_pc;
    logic [31:0]            r_head_inst, r_skid_inst;
    logic                   r_branch_tag;
    logic [XLEN-1:0]        r_branch_pc;

    logic                   w_accept;
    logic                   w_pop;
    logic                   w_head_from_in;
    logic                   w_head_from_skid;
    logic                   w_head_clear;
    logic                   w_skid_from_in;

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign occupancy = r_state;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    // A skid entry only ever moves into the head, preserving FIFO order.
    assign w_head_from_in   = w_accept & ((r_state == ST_EMPTY) | ((r_state == ST_HALF) & w_pop));
    assign w_skid_from_in   = w_accept & (r_state == ST_HALF) & ~w_pop;
    assign w_head_from_skid = (r_state == ST_FULL) & w_pop;
    assign w_head_clear     = (r_state == ST_HALF) & w_pop & ~w_accept;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_HALF;
            ST_HALF: begin
                if (w_accept & ~w_pop)      w_state_nxt = ST_FULL;
                else if (~w_accept & w_pop) w_state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (w_pop) w_state_nxt = ST_HALF;
            default:  w_state_nxt = ST_EMPTY;
        endcase
        if (flush) w_state_nxt = ST_EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Invalid entries are kept at zero so bubbles are clean regardless of gating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_payload <= '0;
            r_head_pc      <= '0;
            r_head_inst    <= '0;
            r_skid_payload <= '0;
            r_skid_pc      <= '0;
            r_skid_inst    <= '0;
        end else if (flush) begin
            r_head_payload <= '0;
            r_head_pc      <= '0;
            r_head_inst    <= '0;
            r_skid_payload <= '0;
            r_skid_pc      <= '0;
            r_skid_inst    <= '0;
        end else begin
            if (w_head_from_in) begin
                r_head_payload <= in_payload;
                r_head_pc      <= in_pc;
                r_head_inst    <= in_inst;
            end else if (w_head_from_skid) begin
                r_head_payload <= r_skid_payload;
                r_head_pc      <= r_skid_pc;
                r_head_inst    <= r_skid_inst;
                r_skid_payload <= '0;
                r_skid_pc      <= '0;
                r_skid_inst    <= '0;
            end else if (w_head_clear) begin
                r_head_payload <= '0;
                r_head_pc      <= '0;
                r_head_inst    <= '0;
            end
            if (w_skid_from_in) begin
                r_skid_payload <= in_payload;
                r_skid_pc      <= in_pc;
                r_skid_inst    <= in_inst;
            end
        end
    end

    // A branch in the same beat as a slot end opens a new shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_tag <= 1'b0;
            r_branch_pc  <= '0;
        end else if (flush) begin
            r_branch_tag <= 1'b0;
            r_branch_pc  <= '0;
        end else if (w_accept) begin
            if (in_branch) begin
                r_branch_tag <= 1'b1;
                r_branch_pc  <= in_branch_tgt;
            end else if (r_branch_tag & in_slot_end) begin
                r_branch_tag <= 1'b0;
                r_branch_pc  <= '0;
            end
        end
    end

    assign branch_tag = r_branch_tag;
    assign branch_pc  = r_branch_pc;

    generate
        if (ZERO_BUBBLE != 0) begin : g_zero_bubble
            assign out_payload = out_valid ? r_head_payload : '0;
            assign out_pc      = out_valid ? r_head_pc      : '0;
            assign out_inst    = out_valid ? r_head_inst    : '0;
        end else begin : g_raw_head
            assign out_payload = r_head_payload;
            assign out_pc      = r_head_pc;
            assign out_inst    = r_head_inst;
        end
    endgenerate

endmodule
`default_nettype wire
